packet_action_exec: RTL and testbench

- Egress stage directly downstream of the upper packet FIFO.
- Consumes that FIFO's byte stream together with the per-packet action word, which arrives with a one-cycle start-of-packet pulse.
- Executes the action: forward, drop, rewrite the destination MAC, or redirect to the CPU port.
- Presents edited packets on a registered valid/ready byte stream to the egress MAC/port mux, with the egress port number attached; also keeps per-outcome packet counters.

---
 rtl/packet_action_exec_if.sv | 29 ++
 rtl/packet_action_exec.sv | 166 ++++++++++++++++
 tb/tb_packet_action_exec.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_action_exec_if.sv
// Byte-stream bundle for the packet action stage: FIFO-side input with the
// per-packet action word, and the registered egress stream toward the port mux.
interface packet_action_exec_if #(
  parameter int unsigned ACTION_W = 64,
  parameter int unsigned PORT_W   = 3
);
  logic                in_sop;
  logic [ACTION_W-1:0] in_action;
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_last;
  logic                in_ready;
  logic                out_valid;
  logic [7:0]          out_data;
  logic                out_last;
  logic                out_sop;
  logic [PORT_W-1:0]   out_port;
  logic                out_ready;

  modport master (
    output in_sop, in_action, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sop, out_port
  );

  modport slave (
    input  in_sop, in_action, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sop, out_port
  );
endinterface

// File: rtl/packet_action_exec.sv
// Egress action stage: forwards, drops, rewrites the destination MAC or
// redirects packets to the CPU port, with per-outcome packet counters.
module packet_action_exec #(
  parameter int unsigned ACTION_W = 64,
  parameter int unsigned PORT_W   = 3,
  parameter int unsigned CPU_PORT = 7,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packet_action_exec_if.slave  bus,
  output logic [CNT_W-1:0]     fwd_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned OP_LSB   = ACTION_W - 2;
  localparam int unsigned PORT_LSB = OP_LSB - PORT_W;
  localparam int unsigned MAC_W    = 48;
  localparam int unsigned IDX_W    = 3;

  localparam logic [1:0] OP_DROP = 2'd1;
  localparam logic [1:0] OP_RWR  = 2'd2;
  localparam logic [1:0] OP_CPU  = 2'd3;
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(6);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [PORT_W-1:0]  port_q;
  logic [MAC_W-1:0]   mac_q;
  logic [IDX_W-1:0]   idx_q;
  logic               out_valid_q;
  logic [7:0]         out_data_q;
  logic               out_last_q;
  logic               out_sop_q;
  logic [PORT_W-1:0]  out_port_q;
  logic [CNT_W-1:0]   fwd_cnt_q;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic               in_ready_c;
  logic               sop_take;
  logic [1:0]         new_op;
  logic [PORT_W-1:0]  new_port;
  logic [1:0]         cur_op;
  logic [PORT_W-1:0]  cur_port;
  logic [MAC_W-1:0]   cur_mac;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_drop;
  logic               in_pkt;
  logic               accept;
  logic               pkt_byte;
  logic               pkt_end;
  logic               load;
  logic               err_evt;
  logic [7:0]         edit_byte;
  logic [IDX_W-1:0]   idx_inc;
  logic               unused_act_bits;

  assign unused_act_bits = ^bus.in_action[PORT_LSB-1:MAC_W];

  // Single output register: accept whenever it is empty or draining this cycle.
  assign in_ready_c = (state_q == S_DROP) || !out_valid_q || bus.out_ready;

  // A start-of-packet in IDLE applies its action to a byte arriving the same cycle.
  always_comb begin
    sop_take = (state_q == S_IDLE) && bus.in_sop;
    new_op   = bus.in_action[OP_LSB +: 2];
    new_port = (new_op == OP_CPU) ? PORT_W'(CPU_PORT) : bus.in_action[PORT_LSB +: PORT_W];
    cur_op   = op_q;
    cur_port = port_q;
    cur_mac  = mac_q;
    cur_idx  = idx_q;
    cur_drop = (state_q == S_DROP);
    if (sop_take) begin
      cur_op   = new_op;
      cur_port = new_port;
      cur_mac  = bus.in_action[MAC_W-1:0];
      cur_idx  = '0;
      cur_drop = (new_op == OP_DROP);
    end
    in_pkt   = sop_take || (state_q != S_IDLE);
    accept   = bus.in_valid && in_ready_c;
    pkt_byte = accept && in_pkt;
    pkt_end  = pkt_byte && bus.in_last;
    load     = pkt_byte && !cur_drop;
    err_evt  = (accept && !in_pkt) || (bus.in_sop && (state_q != S_IDLE));
    idx_inc  = (cur_idx == IDX_SAT) ? IDX_SAT : cur_idx + IDX_W'(1);
  end

  // Destination MAC overlay on the first six bytes of a rewritten packet.
  always_comb begin
    edit_byte = bus.in_data;
    if (cur_op == OP_RWR) begin
      case (cur_idx)
        3'd0:    edit_byte = cur_mac[47:40];
        3'd1:    edit_byte = cur_mac[39:32];
        3'd2:    edit_byte = cur_mac[31:24];
        3'd3:    edit_byte = cur_mac[23:16];
        3'd4:    edit_byte = cur_mac[15:8];
        3'd5:    edit_byte = cur_mac[7:0];
        default: edit_byte = bus.in_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      port_q      <= '0;
      mac_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sop_q   <= 1'b0;
      out_port_q  <= '0;
      fwd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (sop_take) begin
        op_q    <= new_op;
        port_q  <= new_port;
        mac_q   <= bus.in_action[MAC_W-1:0];
        state_q <= (new_op == OP_DROP) ? S_DROP : S_PASS;
      end
      if (pkt_byte) begin
        idx_q <= idx_inc;
      end
      if (pkt_end) begin
        state_q <= S_IDLE;
        idx_q   <= '0;
        if (cur_drop) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        else          fwd_cnt_q  <= fwd_cnt_q + CNT_W'(1);
      end
      if (err_evt) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      // Output beat holds until taken; a new load only happens when it is free.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= edit_byte;
        out_last_q  <= bus.in_last;
        out_sop_q   <= (cur_idx == '0);
        out_port_q  <= cur_port;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_port  = out_port_q;
  assign fwd_cnt       = fwd_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_packet_action_exec.sv
// Directed bench for packet_action_exec: forward, drop, MAC rewrite, CPU
// redirect under backpressure, protocol errors and mid-packet reset.
module tb_packet_action_exec;
  localparam int unsigned ACTION_W = 64;
  localparam int unsigned PORT_W   = 3;
  localparam int unsigned CNT_W    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] fwd_cnt, drop_cnt, err_cnt;

  always #5 clk = ~clk;

  packet_action_exec_if #(.ACTION_W(ACTION_W), .PORT_W(PORT_W)) bus ();

  packet_action_exec #(.ACTION_W(ACTION_W), .PORT_W(PORT_W), .CPU_PORT(7), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fwd_cnt  (fwd_cnt),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       s;
    logic [2:0] p;
    int         c;
  } beat_t;

  beat_t       got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  pkt_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          vld_seen = 0;
  int          lat_cyc = 0;
  bit          bp_chk = 0;
  bit          tog_en = 0;
  bit          hold_pend = 0;
  logic [12:0] hold_val = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] act(input logic [1:0] op, input logic [2:0] port,
                                      input logic [47:0] mac);
    return {op, port, 11'b0, mac};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bounce out_ready every cycle while backpressure is enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (tog_en) bus.out_ready = ~bus.out_ready;
  end

  // Output monitor: collects taken beats and checks hold/ready behaviour.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) vld_seen++;
      if (hold_pend) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_beat", 64'({bus.out_data, bus.out_last, bus.out_sop, bus.out_port}),
              64'(hold_val));
      end
      if (bp_chk) check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready)
        got_q.push_back('{d: bus.out_data, l: bus.out_last, s: bus.out_sop, p: bus.out_port, c: cyc});
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = {bus.out_data, bus.out_last, bus.out_sop, bus.out_port};
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic push(input logic [7:0] d, input logic l, input logic sop, input logic [63:0] a);
    bit acc = 1'b0;
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.in_sop    = sop;
    bus.in_action = a;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc && sop) lat_cyc = cyc;
      if (!acc) stalls++;
      bus.in_sop = 1'b0;
      n++;
    end
    if (!acc) check("push_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] a);
    foreach (pkt_q[i]) push(pkt_q[i], logic'(i == pkt_q.size() - 1), logic'(i == 0), a);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pkt(input string tag, input logic [2:0] port, input bit chk_lat);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(got_q[i].d), 64'(exp_q[i]));
      check($sformatf("%s_sop%0d", tag, i), 64'(got_q[i].s), 64'(i == 0));
      check($sformatf("%s_last%0d", tag, i), 64'(got_q[i].l), 64'(i == exp_q.size() - 1));
      check($sformatf("%s_port%0d", tag, i), 64'(got_q[i].p), 64'(port));
      if (chk_lat) check($sformatf("%s_cyc%0d", tag, i), 64'(got_q[i].c), 64'(lat_cyc + i));
    end
    got_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_sop = 1'b0; bus.in_action = '0; bus.in_valid = 1'b0;
    bus.in_data = '0;  bus.in_last = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sop", 64'(bus.out_sop), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_port", 64'(bus.out_port), 64'd0);
    check("rst_cnts", 64'({fwd_cnt, drop_cnt} | 64'(err_cnt)), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain(2);

    // Plain forward, full throughput, 1-cycle latency
    pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q = pkt_q;
    send_pkt(act(2'd0, 3'd2, 48'h0));
    drain(4);
    expect_pkt("fwd", 3'd2, 1'b1);
    check("fwd_cnt1", 64'(fwd_cnt), 64'd1);

    // Drop with out_ready low: never stalls, never emits
    bus.out_ready = 1'b0;
    stalls = 0;
    vld_seen = 0;
    pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    send_pkt(act(2'd1, 3'd4, 48'h0));
    drain(3);
    check("drop_stalls", 64'(stalls), 64'd0);
    check("drop_valid_seen", 64'(vld_seen), 64'd0);
    check("drop_cnt1", 64'(drop_cnt), 64'd1);
    check("drop_fwd_cnt", 64'(fwd_cnt), 64'd1);
    bus.out_ready = 1'b1;
    got_q.delete();
    pkt_q = '{8'hA1, 8'hA2, 8'hA3};
    exp_q = pkt_q;
    send_pkt(act(2'd0, 3'd5, 48'h0));
    drain(4);
    expect_pkt("after_drop", 3'd5, 1'b1);
    check("fwd_cnt2", 64'(fwd_cnt), 64'd2);

    // Destination MAC rewrite, long and truncated packets
    pkt_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h06, 8'h07};
    send_pkt(act(2'd2, 3'd4, 48'hAABBCCDDEEFF));
    drain(4);
    expect_pkt("rwr8", 3'd4, 1'b1);
    pkt_q = '{8'h00, 8'h01, 8'h02};
    exp_q = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(act(2'd2, 3'd0, 48'hAABBCCDDEEFF));
    drain(4);
    expect_pkt("rwr3", 3'd0, 1'b1);
    check("fwd_cnt4", 64'(fwd_cnt), 64'd4);

    // CPU redirect under toggling backpressure
    stalls = 0;
    bp_chk = 1'b1;
    tog_en = 1'b1;
    pkt_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    exp_q = pkt_q;
    send_pkt(act(2'd3, 3'd1, 48'h0));
    drain(10);
    bp_chk = 1'b0;
    tog_en = 1'b0;
    bus.out_ready = 1'b1;
    drain(3);
    expect_pkt("cpu", 3'd7, 1'b0);
    check("cpu_stalled", 64'(stalls > 0), 64'd1);
    check("fwd_cnt5", 64'(fwd_cnt), 64'd5);

    // Stray byte, then SOP inside an active packet
    push(8'h99, 1'b1, 1'b0, 64'h0);
    check("err_stray", 64'(err_cnt), 64'd1);
    push(8'hC1, 1'b0, 1'b1, act(2'd0, 3'd3, 48'h0));
    push(8'hC2, 1'b0, 1'b0, 64'h0);
    push(8'hC3, 1'b0, 1'b1, act(2'd1, 3'd6, 48'h0));
    push(8'hC4, 1'b1, 1'b0, 64'h0);
    drain(4);
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    expect_pkt("err_pkt", 3'd3, 1'b0);
    check("err_cnt2", 64'(err_cnt), 64'd2);
    check("err_fwd_cnt", 64'(fwd_cnt), 64'd6);
    check("err_drop_cnt", 64'(drop_cnt), 64'd1);

    // Reset after 3 of 6 bytes; the tail is stray
    push(8'hD1, 1'b0, 1'b1, act(2'd0, 3'd1, 48'h0));
    push(8'hD2, 1'b0, 1'b0, 64'h0);
    push(8'hD3, 1'b0, 1'b0, 64'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_cnts", 64'({fwd_cnt, drop_cnt} | 64'(err_cnt)), 64'd0);
    drain(1);
    got_q.delete();
    push(8'hD4, 1'b0, 1'b0, 64'h0);
    push(8'hD5, 1'b0, 1'b0, 64'h0);
    push(8'hD6, 1'b1, 1'b0, 64'h0);
    drain(3);
    check("mrst_err_cnt", 64'(err_cnt), 64'd3);
    check("mrst_fwd_cnt", 64'(fwd_cnt), 64'd0);
    check("mrst_no_out", 64'(got_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
